// File: rtl/can_fd_pkg.sv
// Shared types and constants for the CAN FD transmit queue: frame-info word
// layout, DLC-to-length decode, host address map and head-lock states.
package can_fd_pkg;

  localparam int         MAX_WORDS_DEF = 18;
  localparam logic [7:0] WIN_BASE      = 8'h40;
  localparam logic [7:0] CMD_ADDR      = 8'h88;

  typedef struct packed {
    logic [22:0] rsvd;
    logic        esi;
    logic        brs;
    logic        fdf;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
  } frame_info_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} lock_state_e;

  // Classic frames saturate at 8 bytes; FD frames step up to 64.
  function automatic logic [6:0] dlc_to_len(input frame_info_t fi);
    logic [6:0] len;
    if (fi.rtr)                len = 7'd0;
    else if (fi.dlc <= 4'd8)   len = {3'b000, fi.dlc};
    else if (!fi.fdf)          len = 7'd8;
    else begin
      case (fi.dlc)
        4'd9:    len = 7'd12;
        4'd10:   len = 7'd16;
        4'd11:   len = 7'd20;
        4'd12:   len = 7'd24;
        4'd13:   len = 7'd32;
        4'd14:   len = 7'd48;
        default: len = 7'd64;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/can_fd_tx_fifo_if.sv
// Host register window plus bit-stream-processor head access for the TX queue.
interface can_fd_tx_fifo_if #(parameter int DEPTH = 4) ();
  localparam int LW = $clog2(DEPTH + 1);

  logic          reset_mode;
  logic          we;
  logic [7:0]    addr;
  logic [31:0]   data_in;
  logic          transmit_buffer_status;
  logic          tx_fifo_full;
  logic          tx_fifo_empty;
  logic [LW-1:0] tx_fifo_level;
  logic          overflow;
  logic          tx_frame_valid;
  logic [31:0]   tx_frame_info;
  logic [6:0]    tx_data_len;
  logic [4:0]    tx_rd_idx;
  logic [31:0]   tx_rd_data;
  logic          tx_start;
  logic          tx_done;
  logic          tx_release;
  logic          tx_busy;

  modport master (
    output reset_mode, we, addr, data_in, tx_rd_idx, tx_start, tx_done, tx_release,
    input  transmit_buffer_status, tx_fifo_full, tx_fifo_empty, tx_fifo_level, overflow,
           tx_frame_valid, tx_frame_info, tx_data_len, tx_rd_data, tx_busy
  );

  modport slave (
    input  reset_mode, we, addr, data_in, tx_rd_idx, tx_start, tx_done, tx_release,
    output transmit_buffer_status, tx_fifo_full, tx_fifo_empty, tx_fifo_level, overflow,
           tx_frame_valid, tx_frame_info, tx_data_len, tx_rd_data, tx_busy
  );
endinterface

// File: rtl/can_tx_slot_ram.sv
// Frame slot storage: one sync write port, one sync read port with a reset
// output register, and a combinational tap of the head slot's info word.
module can_tx_slot_ram #(
  parameter int WORDS = 72,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic [AW-1:0] tap_addr,
  output logic [31:0]   tap_data
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else      rdata <= rd_en ? mem[raddr] : '0;

  assign tap_data = mem[tap_addr];

endmodule

// File: rtl/can_fd_tx_fifo.sv
// DEPTH-slot CAN FD transmit queue with host staging window and head lock FSM.
// Define CAN_TX_FIFO_ABORT_EN to make command bit 1 flush unlocked slots.
module can_fd_tx_fifo
  import can_fd_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input logic             clk,
  input logic             rst,
  can_fd_tx_fifo_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH * MAX_WORDS);

  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [LW-1:0] level, lvl_nxt;
  lock_state_e   state;
  logic          full_q, empty_q, status_q, valid_q, ovf_q, busy_q;

  logic          wr_gate, win_hit, cmd_wr, commit_req, commit_ok, abort, pop, keep, rd_en;
  logic [7:0]    win_off;
  logic [AW-1:0] waddr, raddr, tap_addr;
  logic [31:0]   tap_data;

  // Staging and commands are blocked while full so the head slot is never overwritten.
  assign wr_gate    = bus.we && !bus.reset_mode && !full_q;
  assign win_off    = bus.addr - WIN_BASE;
  assign win_hit    = wr_gate && (bus.addr >= WIN_BASE) && (bus.addr[1:0] == 2'b00) &&
                      (32'(win_off[7:2]) < MAX_WORDS);
  assign cmd_wr     = wr_gate && (bus.addr == CMD_ADDR);
  assign commit_req = bus.we && !bus.reset_mode && (bus.addr == CMD_ADDR) && bus.data_in[0];

`ifdef CAN_TX_FIFO_ABORT_EN
  assign abort = cmd_wr && bus.data_in[1];
`else
  assign abort = 1'b0;
`endif

  assign commit_ok = commit_req && !full_q && !abort;
  assign pop       = (state == ST_LOCKED) && bus.tx_done;
  assign keep      = (state == ST_LOCKED) && !bus.tx_done;

  always_comb begin
    rd_nxt  = rd_ptr + PW'(pop);
    wr_nxt  = wr_ptr + PW'(commit_ok);
    lvl_nxt = level + LW'(commit_ok) - LW'(pop);
    if (abort) begin
      wr_nxt  = rd_nxt + PW'(keep);
      lvl_nxt = LW'(keep);
    end
    if (bus.reset_mode) begin
      rd_nxt  = '0;
      wr_nxt  = '0;
      lvl_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      status_q <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      level    <= lvl_nxt;
      full_q   <= (lvl_nxt == LW'(DEPTH));
      empty_q  <= (lvl_nxt == '0);
      status_q <= (lvl_nxt != LW'(DEPTH));
      valid_q  <= (lvl_nxt != '0);
      ovf_q    <= commit_req && full_q;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
    end else if (bus.reset_mode) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (bus.tx_start && valid_q) begin
            state  <= ST_LOCKED;
            busy_q <= 1'b1;
          end
        ST_LOCKED:
          if (bus.tx_done || bus.tx_release) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end

  assign rd_en    = 32'(bus.tx_rd_idx) < MAX_WORDS;
  assign waddr    = AW'(wr_ptr) * AW'(MAX_WORDS) + AW'(win_off[7:2]);
  assign raddr    = AW'(rd_ptr) * AW'(MAX_WORDS) + AW'(bus.tx_rd_idx);
  assign tap_addr = AW'(rd_ptr) * AW'(MAX_WORDS);

  can_tx_slot_ram #(.WORDS(DEPTH * MAX_WORDS), .AW(AW)) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (win_hit),
    .waddr    (waddr),
    .wdata    (bus.data_in),
    .rd_en    (rd_en),
    .raddr    (raddr),
    .rdata    (bus.tx_rd_data),
    .tap_addr (tap_addr),
    .tap_data (tap_data)
  );

  // Slot storage is unreset, so the info tap is masked until a frame is committed.
  assign bus.tx_frame_info          = valid_q ? tap_data : 32'h0;
  assign bus.tx_data_len            = valid_q ? dlc_to_len(frame_info_t'(tap_data)) : 7'd0;
  assign bus.tx_frame_valid         = valid_q;
  assign bus.tx_fifo_full           = full_q;
  assign bus.tx_fifo_empty          = empty_q;
  assign bus.transmit_buffer_status = status_q;
  assign bus.tx_fifo_level          = level;
  assign bus.overflow               = ovf_q;
  assign bus.tx_busy                = busy_q;

endmodule

// File: tb/tb_can_fd_tx_fifo.sv
// Randomized bench for can_fd_tx_fifo against a frame-queue reference model.
module tb_can_fd_tx_fifo;
  localparam int DEPTH = 4;
  localparam int MW    = 18;
`ifdef CAN_TX_FIFO_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif
  localparam int         FD_TBL   [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 24, 32, 48, 64};
  localparam logic [7:0] MISC_ADDR[4]  = '{8'h3C, 8'h8C, 8'h42, 8'h88};

  typedef logic [MW-1:0][31:0] frame_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  can_fd_tx_fifo_if #(.DEPTH(DEPTH)) bus ();
  can_fd_tx_fifo #(.DEPTH(DEPTH), .MAX_WORDS(MW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_chk = 0;
  int          n_err = 0;
  frame_t      q[$];
  frame_t      pend;
  bit          locked;
  bit          exp_ovf;
  bit          rd_known;
  logic [31:0] exp_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_len(input logic [31:0] info);
    int dlc;
    dlc = int'(info[3:0]);
    if (info[4]) return 7'd0;
    if (dlc <= 8) return 7'(dlc);
    if (!info[6]) return 7'd8;
    return 7'(FD_TBL[dlc]);
  endfunction

  // Applies the inputs seen at the last edge to the frame queue.
  task automatic model_edge();
    bit     full, nonempty, cmd, commit, abort;
    int     a, idx;
    frame_t h;
    full     = (q.size() == DEPTH);
    nonempty = (q.size() > 0);
    idx      = int'(bus.tx_rd_idx);
    rd_known = 1'b1;
    if (idx >= MW)     exp_rd = 32'h0;
    else if (nonempty) exp_rd = q[0][idx];
    else               rd_known = 1'b0;
    exp_ovf = 1'b0;
    if (bus.reset_mode) begin
      q.delete();
      locked = 1'b0;
      return;
    end
    a = int'(bus.addr);
    if (bus.we && !full && a >= 64 && a < 64 + 4 * MW && (a % 4) == 0)
      pend[(a - 64) / 4] = bus.data_in;
    cmd     = bus.we && (bus.addr == 8'h88);
    commit  = cmd && bus.data_in[0];
    abort   = ABORT_EN && cmd && bus.data_in[1] && !full;
    exp_ovf = commit && full;
    if (abort) begin
      if (locked && !bus.tx_done) begin
        h = q[0];
        q.delete();
        q.push_back(h);
      end else q.delete();
    end else begin
      if (locked && bus.tx_done) void'(q.pop_front());
      if (commit && !full) q.push_back(pend);
    end
    if (locked) locked = !(bus.tx_done || bus.tx_release);
    else        locked = bus.tx_start && nonempty;
  endtask

  task automatic check_all();
    bit ne;
    ne = q.size() > 0;
    chk("level",  32'(bus.tx_fifo_level), 32'(q.size()));
    chk("full",   32'(bus.tx_fifo_full), 32'(q.size() == DEPTH));
    chk("status", 32'(bus.transmit_buffer_status), 32'(q.size() != DEPTH));
    chk("empty",  32'(bus.tx_fifo_empty), 32'(!ne));
    chk("valid",  32'(bus.tx_frame_valid), 32'(ne));
    chk("busy",   32'(bus.tx_busy), 32'(locked));
    chk("ovf",    32'(bus.overflow), 32'(exp_ovf));
    chk("info",   bus.tx_frame_info, ne ? q[0][0] : 32'h0);
    chk("len",    32'(bus.tx_data_len), ne ? 32'(ref_len(q[0][0])) : 32'h0);
    if (rd_known) chk("rd_data", bus.tx_rd_data, exp_rd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    bus.we         = 1'b0;
    bus.reset_mode = 1'b0;
    bus.tx_start   = 1'b0;
    bus.tx_done    = 1'b0;
    bus.tx_release = 1'b0;
    bus.tx_rd_idx  = 5'($urandom_range(0, 31));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.we      = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    step();
  endtask

  task automatic stage(input logic [31:0] info, input logic [31:0] id);
    wr(8'h40, info);
    wr(8'h44, id);
    for (int k = 2; k < MW; k++) wr(8'(64 + 4 * k), $urandom);
  endtask

  task automatic commit(input bit done);
    bus.tx_done = done;
    wr(8'h88, 32'h1);
  endtask

  task automatic ctl(input bit s, input bit d, input bit r);
    bus.tx_start   = s;
    bus.tx_done    = d;
    bus.tx_release = r;
    step();
  endtask

  task automatic reset_checks();
    chk("rst_status", 32'(bus.transmit_buffer_status), 32'h1);
    chk("rst_empty",  32'(bus.tx_fifo_empty), 32'h1);
    chk("rst_full",   32'(bus.tx_fifo_full), 32'h0);
    chk("rst_level",  32'(bus.tx_fifo_level), 32'h0);
    chk("rst_ovf",    32'(bus.overflow), 32'h0);
    chk("rst_valid",  32'(bus.tx_frame_valid), 32'h0);
    chk("rst_info",   bus.tx_frame_info, 32'h0);
    chk("rst_len",    32'(bus.tx_data_len), 32'h0);
    chk("rst_rd",     bus.tx_rd_data, 32'h0);
    chk("rst_busy",   32'(bus.tx_busy), 32'h0);
    q.delete();
    locked = 1'b0;
  endtask

  initial begin
    bus.reset_mode = 1'b0;
    bus.we         = 1'b0;
    bus.addr       = 8'h0;
    bus.data_in    = 32'h0;
    bus.tx_rd_idx  = 5'd0;
    bus.tx_start   = 1'b0;
    bus.tx_done    = 1'b0;
    bus.tx_release = 1'b0;
    #12;
    reset_checks();
    @(negedge clk) rst = 1'b1;
    step();

    stage(32'h0000_00CF, 32'h123);
    commit(1'b0);
    chk("len64", 32'(bus.tx_data_len), 32'd64);
    chk("lvl1",  32'(bus.tx_fifo_level), 32'd1);

    repeat (3) begin
      stage($urandom, $urandom);
      commit(1'b0);
    end
    chk("full4",  32'(bus.tx_fifo_full), 32'h1);
    chk("stat0",  32'(bus.transmit_buffer_status), 32'h0);
    stage($urandom, $urandom);
    commit(1'b0);
    chk("ovf5",   32'(bus.overflow), 32'h1);
    chk("lvl4",   32'(bus.tx_fifo_level), 32'd4);

    ctl(1, 0, 0); ctl(0, 0, 1);
    ctl(1, 0, 0); ctl(0, 1, 0);
    ctl(1, 0, 0); ctl(0, 1, 0);
    chk("lvl2", 32'(bus.tx_fifo_level), 32'd2);

    for (int i = 0; i < 6; i++) begin
      ctl(1, 0, 0);
      stage($urandom, $urandom);
      commit(1'b1);
    end
    chk("lvl2_wrap", 32'(bus.tx_fifo_level), 32'd2);

    stage($urandom, $urandom);
    commit(1'b0);
    ctl(1, 0, 0);
    wr(8'h88, 32'h2);
    chk("abort_lvl", 32'(bus.tx_fifo_level), ABORT_EN ? 32'd1 : 32'd3);
    bus.tx_rd_idx = 5'd1;
    step();
    ctl(0, 0, 1);

    ctl(1, 0, 0);
    bus.reset_mode = 1'b1;
    step();
    chk("rm_empty", 32'(bus.tx_fifo_empty), 32'h1);
    chk("rm_busy",  32'(bus.tx_busy), 32'h0);
    step();

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0, 1: begin
          stage($urandom, $urandom);
          commit(($urandom % 3) == 0);
        end
        2: ctl(1, 0, 0);
        3: ctl(1'($urandom), 1'($urandom), 1'($urandom));
        4: ctl(0, 1, 0);
        5: begin
          logic [7:0] a;
          a = MISC_ADDR[$urandom_range(0, 3)];
          wr(a, $urandom & 32'hFFFF_FFFE);
        end
        default: begin
          bus.reset_mode = (($urandom % 8) == 0);
          step();
        end
      endcase
    end

    @(posedge clk);
    #3 rst = 1'b0;
    #1 reset_checks();
    @(negedge clk) rst = 1'b1;
    step();
    stage($urandom, $urandom);
    commit(1'b0);
    ctl(1, 0, 0);
    ctl(0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/can_fd_tx_fifo.md
# can_fd_tx_fifo

Multi-slot CAN FD transmit buffer replacing the single-frame tx data register bank. The host stages one frame at a time through a 32-bit register window and commits it into a DEPTH-slot circular queue. The bit stream processor reads the head frame word-by-word, holds it while transmitting, and either pops it on success or releases it for retransmission. The block sits between the register interface and the transmit state machine and supports classic and FD frames up to 64 data bytes.

## Interface
- DEPTH, 4: number of frame slots; power of two, 2..16.
- MAX_WORDS, 18: words per slot: info, identifier, 16 data words.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous and active-low.
- reset_mode  in  1  controller reset mode; flushes the queue and blocks writes.
- we  in  1  host write strobe.
- addr  in  8  host byte address.
- data_in  in  32  host write data.
- transmit_buffer_status  out  1  high when a staging slot is free (the inverse of tx_fifo_full).
- tx_fifo_full  out  1  all DEPTH slots committed.
- tx_fifo_empty  out  1  no committed slots.
- tx_fifo_level  out  $clog2(DEPTH+1)  committed slot count.
- overflow  out  1  one-cycle pulse: commit attempted while full.
- tx_frame_valid  out  1  head slot holds a committed frame.
- tx_frame_info  out  32  word 0 of the head slot.
- tx_data_len  out  7  payload byte count decoded from the head slot's DLC.
- tx_rd_idx  in  5  word index read from the head slot.
- tx_rd_data  out  32  registered read data.
- tx_start  in  1  lock the head slot for transmission.
- tx_done  in  1  transmission succeeded; pop the head slot.
- tx_release  in  1  arbitration lost or error; unlock the head slot without popping it.
- tx_busy  out  1  head slot is locked.

## Operation
- **Address map**
  - Staging window: byte addresses 0x40 + 4·k, k = 0..MAX_WORDS-1. Writes go to word k of the slot at wr_ptr.
  - 0x88: command register. Bit 0 commits the staged frame. Bit 1 aborts (see Configuration).
  - Any other address is ignored.
- **Write gating:** writes are ignored while reset_mode=1 or tx_fifo_full=1.
- **Word 0 layout:** [3:0] DLC, [4] RTR, [5] IDE, [6] FDF, [7] BRS, [8] ESI. Word 1 [28:0] holds the identifier.
- **Commit**
  - Stores nothing new; the staged data is already in the slot.
  - Advances wr_ptr and increments the level.
  - If full: ignored, and overflow pulses.
- **DLC decode (tx_data_len)**
  - RTR=1 gives 0.
  - DLC ≤ 8 gives DLC.
  - FDF=0 with DLC > 8 gives 8.
  - FDF=1 with DLC 9..15 gives 12, 16, 20, 24, 32, 48, 64.
- **Head lock FSM** (states IDLE, LOCKED)
  - IDLE → LOCKED on tx_start while tx_frame_valid=1.
  - LOCKED → IDLE on tx_done: the head is popped, rd_ptr advances and the level decrements.
  - LOCKED → IDLE on tx_release: the head is kept.
  - tx_start while empty or already LOCKED is ignored.
  - tx_done or tx_release while IDLE is ignored.
  - tx_done takes priority over tx_release when both are asserted.
- **Simultaneous events:** commit and pop in the same cycle leave the level unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- **reset_mode=1:** synchronously clears both pointers, the level and the FSM (back to IDLE). This happens even while LOCKED.

## Timing
- **Reset values**
  - transmit_buffer_status=1 and tx_fifo_empty=1.
  - tx_data_len=0 and tx_rd_data=0; all other outputs 0.
  - Slot storage is not reset.
- A staging write in cycle N is visible to a commit in cycle N+1.
- tx_frame_valid, tx_frame_info and tx_data_len update in the cycle after the commit edge.
- tx_rd_data latency is one cycle from tx_rd_idx. Index ≥ MAX_WORDS reads 0.
- Status outputs, tx_busy and tx_frame_valid are registered.
- overflow is high for exactly one cycle.
- A pop at edge N presents the next head's info from cycle N+1.

## Configuration
- CAN_TX_FIFO_ABORT_EN defined: command bit 1 flushes all committed slots except a LOCKED head. wr_ptr is set to rd_ptr+1 if LOCKED, else to rd_ptr, and the level is set to match. If abort and commit are written together, abort wins.
- CAN_TX_FIFO_ABORT_EN undefined: command bit 1 is ignored.

## Structure
- Package can_fd_pkg holds:
  - the frame-info struct matching the word 0 layout;
  - the DLC-to-length function;
  - address constants (0x40 window base, 0x88 command);
  - the MAX_WORDS default.
- One sub-module, can_tx_slot_ram: a DEPTH·MAX_WORDS × 32 array with one synchronous write port and one synchronous read port, plus a combinational word-0 tap for the head slot.

## Test plan
- Write info=0x000000CF (FDF, DLC 15) and id=0x123 to slot 0, commit → tx_frame_valid=1 next cycle, tx_data_len=64, level=1.
- Commit 4 frames with DEPTH=4 → full=1, transmit_buffer_status=0. A 5th commit pulses overflow; the level stays at 4.
- tx_start then tx_release → head is unchanged and tx_busy drops. tx_start then tx_done → rd_ptr advances and the level decrements.
- Commit and tx_done in the same cycle at level 2 → level stays 2; pointers wrap correctly after 6 cycles of such traffic.
- With ABORT_EN, 3 committed and the head LOCKED, write 0x88=0x2 → level=1 and the head is still readable. Without ABORT_EN, the level stays 3.
- Assert reset_mode while LOCKED → empty=1 and tx_busy=0 next cycle. Asserting rst mid-operation gives all reset values.
